uart_regif: RTL and testbench

- Memory-mapped register slave sitting directly upstream of uart_mgr, between the core's peripheral bus and uart_mgr's byte-level core interface.
- Turns 32-bit loads/stores into TX FIFO pushes, RX FIFO pops, status reads and baud configuration.
- Absorbs TX back-pressure with a bounded stall; bytes that wait too long are dropped and flagged.

---
 rtl/uart_regif_pkg.sv | 31 +++
 rtl/uart_regif_if.sv | 32 +++
 rtl/uart_regif.sv | 185 ++++++++++++++++++
 tb/tb_uart_regif.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_regif_pkg.sv
// uart_regif_pkg: shared constants and types for the uart_regif register slave.
//   - register offsets (word index, bus_addr[3:2])
//   - STATUS / CTRL bit positions
//   - FSM state type
//   - default reset value of the baud divider (18 -> 115200)
package uart_regif_pkg;

    localparam logic [1:0] RegData   = 2'd0;
    localparam logic [1:0] RegStatus = 2'd1;
    localparam logic [1:0] RegBaud   = 2'd2;
    localparam logic [1:0] RegCtrl   = 2'd3;

    localparam int unsigned StatTxFull    = 0;
    localparam int unsigned StatRxEmpty   = 1;
    localparam int unsigned StatSwUpgrade = 2;
    localparam int unsigned StatTxDrop    = 3;

    localparam int unsigned CtrlRxIe   = 0;
    localparam int unsigned CtrlTxIe   = 1;
    localparam int unsigned CtrlDropIe = 2;

    localparam logic [7:0] BaudRstDefault = 8'd18;

    typedef enum logic [1:0] {
        StIdle,
        StTxWait,
        StRxPop,
        StRxCap
    } state_e;

endpackage

// File: rtl/uart_regif_if.sv
// uart_regif_if: peripheral bus between the core (master) and uart_regif (slave).
//   req    master->slave  request valid
//   we     master->slave  1 = write, 0 = read
//   addr   master->slave  byte address (ADDR_W bits)
//   wdata  master->slave  write data (XLEN bits)
//   be     master->slave  byte enables (XLEN/8 bits)
//   gnt    slave->master  request accepted this cycle
//   rvalid slave->master  read data valid, one pulse per accepted read
//   rdata  slave->master  read data (XLEN bits)
interface uart_regif_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 4
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   wdata;
    logic [XLEN/8-1:0] be;
    logic              gnt;
    logic              rvalid;
    logic [XLEN-1:0]   rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/uart_regif.sv
// uart_regif: memory-mapped register slave in front of uart_mgr's byte interface.
// Turns bus loads/stores into TX pushes, RX pops, status reads and baud configuration.
// A TX byte waits at most TX_WAIT_MAX cycles for uart_wr_ready, then is dropped and
// the sticky tx_drop status bit is set.
//
// Optional feature macro: UART_REGIF_IRQ_EN (CTRL register + registered level irq).
// Without it CTRL reads 0, ignores writes and irq is tied 0.
//
// Ports:
//   clk, rstb            clock, asynchronous active-low reset
//   bus                  uart_regif_if.slave (req/we/addr/wdata/be -> gnt/rvalid/rdata)
//   uart_wr_req/_data    TX push request and byte, uart_wr_ready = TX FIFO not full
//   uart_rd_req          RX pop request, uart_rd_data valid the cycle after the pop
//   uart_rd_ready        RX pop allowed
//   uart_txfifo_full, uart_rxfifo_empty, during_sw_upgrade   status inputs
//   baudrate_cfg         baud divider to uart_mgr
//   irq                  level interrupt
module uart_regif
    import uart_regif_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned TX_WAIT_MAX = 1024,
    parameter logic [7:0]  BAUD_RST    = BaudRstDefault
) (
    input  logic       clk,
    input  logic       rstb,
    uart_regif_if.slave bus,
    output logic       uart_wr_req,
    output logic [7:0] uart_wr_data,
    input  logic       uart_wr_ready,
    output logic       uart_rd_req,
    input  logic [7:0] uart_rd_data,
    input  logic       uart_rd_ready,
    input  logic       uart_txfifo_full,
    input  logic       uart_rxfifo_empty,
    input  logic       during_sw_upgrade,
    output logic [7:0] baudrate_cfg,
    output logic       irq
);

    localparam int unsigned CntW = $clog2(TX_WAIT_MAX + 1);
    // Last wait cycle: the counter steps to TX_WAIT_MAX on this edge.
    localparam logic [CntW-1:0] WaitLast = CntW'(TX_WAIT_MAX - 1);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            tx_drop_q;
    logic            rvalid_q;
    logic [XLEN-1:0] rdata_q;

    logic            gnt;
    logic            unmapped;
    logic [1:0]      offset;
    logic            wr_en;
    logic [2:0]      ctrl_rd;
    logic [XLEN-1:0] csr_rdata;

    // Address bits above the 4-register window mark an unmapped access.
    if (ADDR_W > 4) begin : g_upper_addr
        assign unmapped = |bus.addr[ADDR_W-1:4];
    end else begin : g_no_upper_addr
        assign unmapped = 1'b0;
    end

    assign offset     = bus.addr[3:2];
    assign gnt        = bus.req & (state_q == StIdle);
    assign wr_en      = gnt & bus.we & ~unmapped & bus.be[0];
    assign bus.gnt    = gnt;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.be[XLEN/8-1:1], bus.wdata[XLEN-1:8], bus.addr[1:0]};

    always_comb begin
        csr_rdata = '0;
        if (!unmapped) begin
            case (offset)
                RegStatus: begin
                    csr_rdata[StatTxFull]    = uart_txfifo_full;
                    csr_rdata[StatRxEmpty]   = uart_rxfifo_empty;
                    csr_rdata[StatSwUpgrade] = during_sw_upgrade;
                    csr_rdata[StatTxDrop]    = tx_drop_q;
                end
                RegBaud: csr_rdata[7:0] = baudrate_cfg;
                RegCtrl: csr_rdata[2:0] = ctrl_rd;
                default: ; // DATA read that reaches here has an empty RX FIFO: reads 0
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            tx_drop_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            uart_wr_req  <= 1'b0;
            uart_wr_data <= '0;
            uart_rd_req  <= 1'b0;
            baudrate_cfg <= BAUD_RST;
        end else begin
            rvalid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (gnt && bus.we) begin
                        if (wr_en) begin
                            case (offset)
                                RegData: begin
                                    uart_wr_data <= bus.wdata[7:0];
                                    uart_wr_req  <= 1'b1;
                                    cnt_q        <= '0;
                                    state_q      <= StTxWait;
                                end
                                // W1C only happens in idle and the drop only in TX wait, so
                                // a set can never be lost to a clear.
                                RegStatus: if (bus.wdata[StatTxDrop]) tx_drop_q <= 1'b0;
                                RegBaud:   baudrate_cfg <= bus.wdata[7:0];
                                default:   ; // CTRL is handled with the irq logic
                            endcase
                        end
                    end else if (gnt) begin
                        if (!unmapped && offset == RegData && !uart_rxfifo_empty) begin
                            uart_rd_req <= 1'b1;
                            state_q     <= StRxPop;
                        end else begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= csr_rdata;
                        end
                    end
                end
                StTxWait: begin
                    // A push accepted on the last wait cycle still counts as delivered.
                    if (uart_wr_ready) begin
                        uart_wr_req <= 1'b0;
                        state_q     <= StIdle;
                    end else if (cnt_q == WaitLast) begin
                        uart_wr_req <= 1'b0;
                        tx_drop_q   <= 1'b1;
                        cnt_q       <= cnt_q + CntW'(1);
                        state_q     <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StRxPop: begin
                    if (uart_rd_ready) begin
                        uart_rd_req <= 1'b0;
                        state_q     <= StRxCap;
                    end
                end
                StRxCap: begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= XLEN'({1'b1, uart_rd_data});
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef UART_REGIF_IRQ_EN
    logic [2:0] ctrl_q;

    assign ctrl_rd = ctrl_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ctrl_q <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr_en && offset == RegCtrl) ctrl_q <= bus.wdata[2:0];
            irq <= (ctrl_q[CtrlRxIe]   & ~uart_rxfifo_empty) |
                   (ctrl_q[CtrlTxIe]   & ~uart_txfifo_full)  |
                   (ctrl_q[CtrlDropIe] & tx_drop_q);
        end
    end
`else
    assign ctrl_rd = '0;
    assign irq     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_regif.sv
module tb_uart_regif;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned TX_WAIT_MAX = 8;

    logic       clk  = 1'b0;
    logic       rstb = 1'b0;
    logic       uart_wr_req;
    logic [7:0] uart_wr_data;
    logic       uart_wr_ready;
    logic       uart_rd_req;
    logic [7:0] uart_rd_data;
    logic       uart_rd_ready;
    logic       uart_txfifo_full;
    logic       uart_rxfifo_empty;
    logic       during_sw_upgrade;
    logic [7:0] baudrate_cfg;
    logic       irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_regif_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus_if ();

    uart_regif #(
        .XLEN       (XLEN),
        .ADDR_W     (ADDR_W),
        .TX_WAIT_MAX(TX_WAIT_MAX),
        .BAUD_RST   (8'h12)
    ) dut (
        .clk              (clk),
        .rstb             (rstb),
        .bus              (bus_if),
        .uart_wr_req      (uart_wr_req),
        .uart_wr_data     (uart_wr_data),
        .uart_wr_ready    (uart_wr_ready),
        .uart_rd_req      (uart_rd_req),
        .uart_rd_data     (uart_rd_data),
        .uart_rd_ready    (uart_rd_ready),
        .uart_txfifo_full (uart_txfifo_full),
        .uart_rxfifo_empty(uart_rxfifo_empty),
        .during_sw_upgrade(during_sw_upgrade),
        .baudrate_cfg     (baudrate_cfg),
        .irq              (irq)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        rxempty;
        logic        txfull;
        logic        upg;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic we, input logic [4:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input logic rxempty, input logic txfull, input logic upg,
                                input logic exp_rvalid, input logic [31:0] exp_rdata);
        vec_t v;
        v.name = name; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
        v.rxempty = rxempty; v.txfull = txfull; v.upg = upg;
        v.exp_rvalid = exp_rvalid; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_drive(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be);
        bus_if.req   = 1'b1;
        bus_if.we    = we;
        bus_if.addr  = addr;
        bus_if.wdata = wdata;
        bus_if.be    = be;
    endtask

    task automatic bus_idle();
        bus_if.req   = 1'b0;
        bus_if.we    = 1'b0;
        bus_if.addr  = '0;
        bus_if.wdata = '0;
        bus_if.be    = '0;
    endtask

    task automatic csr_write(input logic [4:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be);
        bus_drive(1'b1, addr, wdata, be);
        step();
        bus_idle();
    endtask

    task automatic csr_read_check(input string name, input logic [4:0] addr,
                                  input logic [31:0] exp);
        bus_drive(1'b0, addr, '0, '0);
        step();
        bus_idle();
        check({name, "_rvalid"}, 32'(bus_if.rvalid), 32'd1);
        check(name, bus_if.rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ctrl_exp;
`ifdef UART_REGIF_IRQ_EN
        ctrl_exp = 32'h7;
`else
        ctrl_exp = 32'h0;
`endif
        bus_idle();
        uart_wr_ready     = 1'b1;
        uart_rd_ready     = 1'b1;
        uart_rd_data      = 8'hEE;
        uart_txfifo_full  = 1'b0;
        uart_rxfifo_empty = 1'b1;
        during_sw_upgrade = 1'b0;

        // Reset values
        step();
        step();
        check("rst_rvalid", 32'(bus_if.rvalid), 32'd0);
        check("rst_rdata", bus_if.rdata, 32'd0);
        check("rst_wr_req", 32'(uart_wr_req), 32'd0);
        check("rst_wr_data", 32'(uart_wr_data), 32'd0);
        check("rst_rd_req", 32'(uart_rd_req), 32'd0);
        check("rst_baud", 32'(baudrate_cfg), 32'h12);
        check("rst_irq", 32'(irq), 32'd0);
        #3 rstb = 1'b1;
        step();

        // Single-cycle CSR accesses
        vecs.push_back(mk("rd_baud_rst",       0, 5'h08, 32'h0,        4'h0, 1, 0, 0, 1, 32'h12));
        vecs.push_back(mk("rd_status_rst",     0, 5'h04, 32'h0,        4'h0, 1, 0, 0, 1, 32'h2));
        vecs.push_back(mk("rd_status_mix",     0, 5'h04, 32'h0,        4'h0, 0, 1, 1, 1, 32'h5));
        vecs.push_back(mk("wr_baud_be0",       1, 5'h08, 32'h09,       4'h0, 1, 0, 0, 0, 32'h0));
        vecs.push_back(mk("rd_baud_keep",      0, 5'h08, 32'h0,        4'h0, 1, 0, 0, 1, 32'h12));
        vecs.push_back(mk("wr_baud_be1",       1, 5'h08, 32'hFFFFFF09, 4'h1, 1, 0, 0, 0, 32'h0));
        vecs.push_back(mk("rd_baud_new",       0, 5'h08, 32'h0,        4'h0, 1, 0, 0, 1, 32'h09));
        vecs.push_back(mk("wr_unmapped_data",  1, 5'h10, 32'h55,       4'hF, 1, 0, 0, 0, 32'h0));
        vecs.push_back(mk("wr_unmapped_baud",  1, 5'h18, 32'h77,       4'hF, 1, 0, 0, 0, 32'h0));
        vecs.push_back(mk("rd_unmapped",       0, 5'h18, 32'h0,        4'h0, 1, 0, 0, 1, 32'h0));
        vecs.push_back(mk("rd_baud_alias",     0, 5'h08, 32'h0,        4'h0, 1, 0, 0, 1, 32'h09));
        vecs.push_back(mk("wr_data_be0",       1, 5'h00, 32'h66,       4'h2, 1, 0, 0, 0, 32'h0));
        vecs.push_back(mk("rd_data_empty",     0, 5'h00, 32'h0,        4'h0, 1, 0, 0, 1, 32'h0));
        vecs.push_back(mk("wr_ctrl",           1, 5'h0C, 32'h7,        4'h1, 1, 0, 0, 0, 32'h0));
        vecs.push_back(mk("rd_ctrl",           0, 5'h0C, 32'h0,        4'h0, 1, 0, 0, 1, ctrl_exp));
        vecs.push_back(mk("wr_ctrl_clr",       1, 5'h0C, 32'h0,        4'h1, 1, 0, 0, 0, 32'h0));
        vecs.push_back(mk("wr_status_w1c",     1, 5'h04, 32'h8,        4'h1, 1, 0, 0, 0, 32'h0));
        vecs.push_back(mk("rd_addr_lowbits",   0, 5'h0B, 32'h0,        4'h0, 1, 0, 0, 1, 32'h09));

        foreach (vecs[i]) begin
            uart_rxfifo_empty = vecs[i].rxempty;
            uart_txfifo_full  = vecs[i].txfull;
            during_sw_upgrade = vecs[i].upg;
            bus_drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            #1;
            check({vecs[i].name, "_gnt"}, 32'(bus_if.gnt), 32'd1);
            step();
            check({vecs[i].name, "_rvalid"}, 32'(bus_if.rvalid), 32'(vecs[i].exp_rvalid));
            if (vecs[i].exp_rvalid) check(vecs[i].name, bus_if.rdata, vecs[i].exp_rdata);
            check({vecs[i].name, "_wr_req"}, 32'(uart_wr_req), 32'd0);
            check({vecs[i].name, "_rd_req"}, 32'(uart_rd_req), 32'd0);
`ifndef UART_REGIF_IRQ_EN
            check({vecs[i].name, "_irq"}, 32'(irq), 32'd0);
`endif
        end
        bus_idle();
        uart_rxfifo_empty = 1'b1;
        uart_txfifo_full  = 1'b0;
        during_sw_upgrade = 1'b0;
        step();

        // TX push with ready: request at T+1 for one cycle, next grant at T+2
        uart_wr_ready = 1'b1;
        bus_drive(1'b1, 5'h00, 32'h41, 4'h1);
        #1 check("tx_gnt", 32'(bus_if.gnt), 32'd1);
        step();
        check("tx_wr_req_t1", 32'(uart_wr_req), 32'd1);
        check("tx_wr_data_t1", 32'(uart_wr_data), 32'h41);
        bus_drive(1'b0, 5'h08, 32'h0, 4'h0);
        #1 check("tx_gnt_t1", 32'(bus_if.gnt), 32'd0);
        step();
        check("tx_wr_req_t2", 32'(uart_wr_req), 32'd0);
        check("tx_gnt_t2", 32'(bus_if.gnt), 32'd1);
        step();
        bus_idle();
        check("tx_next_rvalid", 32'(bus_if.rvalid), 32'd1);
        check("tx_next_rdata", bus_if.rdata, 32'h09);

        // RX pop: rd_req at T+1 only, data valid at T+2, rvalid at T+3
        uart_rxfifo_empty = 1'b0;
        bus_drive(1'b0, 5'h00, 32'h0, 4'h0);
        #1 check("rx_gnt", 32'(bus_if.gnt), 32'd1);
        step();
        bus_idle();
        check("rx_rd_req_t1", 32'(uart_rd_req), 32'd1);
        check("rx_rvalid_t1", 32'(bus_if.rvalid), 32'd0);
        step();
        uart_rd_data      = 8'h5A;
        uart_rxfifo_empty = 1'b1;
        check("rx_rd_req_t2", 32'(uart_rd_req), 32'd0);
        check("rx_rvalid_t2", 32'(bus_if.rvalid), 32'd0);
        step();
        uart_rd_data = 8'hEE;
        check("rx_rvalid_t3", 32'(bus_if.rvalid), 32'd1);
        check("rx_rdata_t3", bus_if.rdata, 32'h15A);
        step();
        check("rx_rvalid_t4", 32'(bus_if.rvalid), 32'd0);

        // TX drop after TX_WAIT_MAX cycles; a STATUS read stalls meanwhile
        uart_wr_ready = 1'b0;
        csr_write(5'h00, 32'h33, 4'h1);
        bus_drive(1'b0, 5'h04, 32'h0, 4'h0);
        #1;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("drop_wr_req_t%0d", k), 32'(uart_wr_req), 32'd1);
            check($sformatf("drop_gnt_t%0d", k), 32'(bus_if.gnt), 32'd0);
            step();
        end
        check("drop_wr_req_t9", 32'(uart_wr_req), 32'd0);
        check("drop_gnt_t9", 32'(bus_if.gnt), 32'd1);
        step();
        bus_idle();
        check("drop_status_rvalid", 32'(bus_if.rvalid), 32'd1);
        check("drop_status", bus_if.rdata, 32'hA);
        csr_write(5'h04, 32'h8, 4'h0);
        csr_read_check("w1c_be0_keeps", 5'h04, 32'hA);
        csr_write(5'h04, 32'h0, 4'h1);
        csr_read_check("w0_keeps", 5'h04, 32'hA);
        csr_write(5'h04, 32'h8, 4'h1);
        csr_read_check("w1c_clears", 5'h04, 32'h2);

        // Ready arriving on the last wait cycle delivers the byte, no drop
        csr_write(5'h00, 32'h34, 4'h1);
        for (int k = 1; k < 8; k++) step();
        uart_wr_ready = 1'b1;
        check("late_ready_wr_req", 32'(uart_wr_req), 32'd1);
        step();
        check("late_ready_done", 32'(uart_wr_req), 32'd0);
        csr_read_check("late_ready_no_drop", 5'h04, 32'h2);

        // Reset in the middle of a stalled push
        uart_wr_ready = 1'b0;
        csr_write(5'h08, 32'h44, 4'h1);
        csr_write(5'h00, 32'h99, 4'h1);
        check("midrst_wr_req_before", 32'(uart_wr_req), 32'd1);
        #2 rstb = 1'b0;
        #1;
        check("midrst_wr_req", 32'(uart_wr_req), 32'd0);
        check("midrst_wr_data", 32'(uart_wr_data), 32'd0);
        check("midrst_baud", 32'(baudrate_cfg), 32'h12);
        #2 rstb = 1'b1;
        step();
        bus_drive(1'b0, 5'h08, 32'h0, 4'h0);
        #1 check("midrst_gnt_idle", 32'(bus_if.gnt), 32'd1);
        step();
        bus_idle();
        check("midrst_rd_baud", bus_if.rdata, 32'h12);
        uart_wr_ready = 1'b1;

`ifdef UART_REGIF_IRQ_EN
        // RX interrupt follows rxfifo_empty with one cycle of latency
        uart_txfifo_full = 1'b1;
        csr_write(5'h0C, 32'h1, 4'h1);
        step();
        check("irq_idle", 32'(irq), 32'd0);
        uart_rxfifo_empty = 1'b0;
        uart_rd_data      = 8'h21;
        #1 check("irq_same_cycle", 32'(irq), 32'd0);
        step();
        check("irq_set", 32'(irq), 32'd1);
        bus_drive(1'b0, 5'h00, 32'h0, 4'h0);
        step();
        bus_idle();
        check("irq_pop_req", 32'(uart_rd_req), 32'd1);
        step();
        uart_rxfifo_empty = 1'b1;
        check("irq_hold", 32'(irq), 32'd1);
        step();
        check("irq_pop_rdata", bus_if.rdata, 32'h121);
        check("irq_clear", 32'(irq), 32'd0);
`else
        // Without the feature irq never rises, even with pending RX data
        uart_rxfifo_empty = 1'b0;
        uart_txfifo_full  = 1'b0;
        csr_write(5'h0C, 32'h7, 4'h1);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("irq_off_%0d", k), 32'(irq), 32'd0);
        end
        uart_rxfifo_empty = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
